// File: rtl/ex_muldiv.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per clock: 32 iterations in CALC, then sign fix-up and write-back in FIX.
module ex_muldiv (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        inStart,
    input  logic [3:0]  inMDop,
    input  logic [31:0] inOpA,
    input  logic [31:0] inOpB,
    input  logic        inFlush,
    output logic        outStall,
    output logic        outDone,
    output logic [31:0] outHI,
    output logic [31:0] outLO,
    output logic [31:0] outMFresult
);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MFHI  = 4'b0101;
    localparam logic [3:0] OP_MFLO  = 4'b0110;
    localparam logic [3:0] OP_MTHI  = 4'b0111;
    localparam logic [3:0] OP_MTLO  = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [63:0] acc;
    logic [31:0] op_a_raw;
    logic [31:0] mag_b;
    logic        is_div;
    logic        neg_main;
    logic        neg_rem;
    logic        div_zero;

    logic        op_arith;
    logic        op_hilo;
    logic        op_signed;
    logic        op_is_div;
    logic        accept;
    logic        mt_write;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    assign op_arith  = (inMDop == OP_MULT) || (inMDop == OP_MULTU) ||
                       (inMDop == OP_DIV)  || (inMDop == OP_DIVU);
    assign op_hilo   = (inMDop == OP_MFHI) || (inMDop == OP_MFLO) ||
                       (inMDop == OP_MTHI) || (inMDop == OP_MTLO);
    assign op_signed = (inMDop == OP_MULT) || (inMDop == OP_DIV);
    assign op_is_div = (inMDop == OP_DIV)  || (inMDop == OP_DIVU);

    // outDone blocks a restart of the same instruction still held in ID/EX.
    assign accept   = (state == IDLE) && inStart && !outDone && !inFlush && op_arith;
    assign mt_write = (state == IDLE) && inStart && !inFlush &&
                      ((inMDop == OP_MTHI) || (inMDop == OP_MTLO));

    assign abs_a = (op_signed && inOpA[31]) ? (32'd0 - inOpA) : inOpA;
    assign abs_b = (op_signed && inOpB[31]) ? (32'd0 - inOpB) : inOpB;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
    logic [32:0] div_cand;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [63:0] div_next;
    assign div_cand = acc[63:31];
    assign div_diff = div_cand - {1'b0, mag_b};
    assign div_ge   = !div_diff[32];
    assign div_next = {(div_ge ? div_diff[31:0] : div_cand[31:0]), acc[30:0], div_ge};

    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;
    assign prod_fix = neg_main ? (64'd0 - acc) : acc;
    assign quot_fix = neg_main ? (32'd0 - acc[31:0])  : acc[31:0];
    assign rem_fix  = neg_rem  ? (32'd0 - acc[63:32]) : acc[63:32];

    always_comb begin
        fix_hi = prod_fix[63:32];
        fix_lo = prod_fix[31:0];
        if (is_div) begin
            if (div_zero) begin
                fix_hi = op_a_raw;
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                fix_hi = rem_fix;
                fix_lo = quot_fix;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (cnt == 6'd31) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (inFlush) state_nxt = IDLE;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            cnt      <= 6'd0;
            acc      <= 64'd0;
            op_a_raw <= 32'd0;
            mag_b    <= 32'd0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            outDone  <= 1'b0;
            outHI    <= 32'd0;
            outLO    <= 32'd0;
        end else begin
            outDone <= 1'b0;
            if (inFlush) begin
                cnt <= 6'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            cnt      <= 6'd0;
                            acc      <= {32'd0, abs_a};
                            op_a_raw <= inOpA;
                            mag_b    <= abs_b;
                            is_div   <= op_is_div;
                            neg_main <= op_signed && (inOpA[31] ^ inOpB[31]);
                            neg_rem  <= op_signed && inOpA[31];
                            div_zero <= (inOpB == 32'd0);
                        end
                        if (mt_write) begin
                            if (inMDop == OP_MTHI) outHI <= inOpA;
                            else                   outLO <= inOpA;
                        end
                    end
                    CALC: begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt + 6'd1;
                    end
                    FIX: begin
                        outHI   <= fix_hi;
                        outLO   <= fix_lo;
                        outDone <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign outStall = (state != IDLE) ||
                      (inStart && op_arith && !outDone) ||
                      (inStart && op_hilo && (state != IDLE));

    always_comb begin
        outMFresult = 32'd0;
        case (inMDop)
            OP_MFHI: outMFresult = outHI;
            OP_MFLO: outMFresult = outLO;
            default: outMFresult = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed and randomized checks of ex_muldiv against a plain-arithmetic HI/LO model.
module tb_ex_muldiv;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        inStart = 1'b0;
    logic [3:0]  inMDop = 4'd0;
    logic [31:0] inOpA = 32'd0;
    logic [31:0] inOpB = 32'd0;
    logic        inFlush = 1'b0;
    logic        outStall;
    logic        outDone;
    logic [31:0] outHI;
    logic [31:0] outLO;
    logic [31:0] outMFresult;

    int n_cmp = 0;
    int n_err = 0;

    ex_muldiv dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .inStart     (inStart),
        .inMDop      (inMDop),
        .inOpA       (inOpA),
        .inOpB       (inOpB),
        .inFlush     (inFlush),
        .outStall    (outStall),
        .outDone     (outDone),
        .outHI       (outHI),
        .outLO       (outLO),
        .outMFresult (outMFresult)
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Architectural results computed with 64-bit integer arithmetic.
    function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     prod;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            OP_MULT: begin
                prod = sa * sb;
                hi = prod[63:32];
                lo = prod[31:0];
            end
            OP_MULTU: begin
                prod = ua * ub;
                hi = prod[63:32];
                lo = prod[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else if (op == OP_DIV) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    lo = sq[31:0];
                    hi = sr[31:0];
                end else begin
                    lo = 32'(ua / ub);
                    hi = 32'(ua % ub);
                end
            end
            default: ;
        endcase
    endfunction

    // Issue an arithmetic op held in ID/EX; returns at the outDone cycle.
    task automatic run_arith(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input bit jitter, input string tag,
                             output logic [31:0] eh, output logic [31:0] el);
        ref_model(op, a, b, eh, el);
        inStart = 1'b1;
        inMDop  = op;
        inOpA   = a;
        inOpB   = b;
        settle();
        chk({tag, " stall_at_start"}, 32'(outStall), 32'd1);
        step();
        for (int k = 1; k <= 33; k++) begin
            chk({tag, " busy"}, 32'({outStall, outDone}), 32'b10);
            if (jitter) begin
                inMDop = 4'($urandom_range(1, 8));
                inOpA  = $urandom;
                inOpB  = $urandom;
            end
            step();
        end
        chk({tag, " done_cycle"}, 32'({outStall, outDone}), 32'b01);
        chk({tag, " hi"}, outHI, eh);
        chk({tag, " lo"}, outLO, el);
        inMDop = op;
        inOpA  = a;
        inOpB  = b;
    endtask

    task automatic retire(input string tag, input logic [31:0] eh, input logic [31:0] el);
        step();
        inStart = 1'b0;
        inMDop  = OP_NOP;
        settle();
        chk({tag, " no_restart"}, 32'({outStall, outDone}), 32'b00);
        chk({tag, " hi_kept"}, outHI, eh);
        chk({tag, " lo_kept"}, outLO, el);
    endtask

    logic [31:0] eh, el;
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    logic [31:0] corners [6];
    bit          saw_done;

    initial begin
        corners = '{32'h0, 32'h1, 32'h2, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

        #3;
        chk("reset_state", 32'({outStall, outDone}), 32'b00);
        chk("reset_hi", outHI, 32'd0);
        chk("reset_lo", outLO, 32'd0);
        @(negedge CLOCK);
        RESET = 1'b1;
        step();

        run_arith(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, "mult_neg2x3", eh, el);
        chk("mult_neg2x3 hi_const", outHI, 32'hFFFF_FFFF);
        chk("mult_neg2x3 lo_const", outLO, 32'hFFFF_FFFA);
        retire("mult_neg2x3", eh, el);

        run_arith(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max", eh, el);
        chk("multu_max hi_const", outHI, 32'hFFFF_FFFE);
        chk("multu_max lo_const", outLO, 32'h0000_0001);
        retire("multu_max", eh, el);

        run_arith(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7_2", eh, el);
        chk("div_neg7_2 lo_const", outLO, 32'hFFFF_FFFD);
        chk("div_neg7_2 hi_const", outHI, 32'hFFFF_FFFF);
        retire("div_neg7_2", eh, el);

        run_arith(OP_DIVU, 32'd7, 32'd0, 1'b0, "divu_by0", eh, el);
        chk("divu_by0 lo_const", outLO, 32'hFFFF_FFFF);
        chk("divu_by0 hi_const", outHI, 32'd7);
        retire("divu_by0", eh, el);

        run_arith(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf", eh, el);
        chk("div_ovf lo_const", outLO, 32'h8000_0000);
        chk("div_ovf hi_const", outHI, 32'd0);
        retire("div_ovf", eh, el);

        run_arith(OP_DIV, 32'hFFFF_FFF0, 32'd0, 1'b1, "div_by0_signed", eh, el);
        retire("div_by0_signed", eh, el);

        // MFLO follows a DIV in the pipeline and must see the fresh quotient.
        run_arith(OP_DIV, 32'd100, 32'hFFFF_FFF9, 1'b0, "div_mflo", eh, el);
        step();
        inMDop = OP_MFLO;
        settle();
        chk("div_mflo mf_stall", 32'(outStall), 32'd0);
        chk("div_mflo mf_result", outMFresult, el);
        inMDop = OP_MFHI;
        settle();
        chk("div_mflo mfhi_result", outMFresult, eh);
        inStart = 1'b0;
        inMDop  = OP_NOP;
        settle();

        // Preset HI/LO, then kill a MULT mid-flight.
        inStart = 1'b1;
        inMDop  = OP_MTHI;
        inOpA   = 32'h11;
        settle();
        chk("mthi stall", 32'(outStall), 32'd0);
        step();
        chk("mthi hi", outHI, 32'h11);
        inMDop = OP_MTLO;
        inOpA  = 32'h22;
        step();
        chk("mtlo lo", outLO, 32'h22);
        inMDop  = OP_MTHI;
        inOpA   = 32'h99;
        inFlush = 1'b1;
        step();
        chk("mthi_flushed hi", outHI, 32'h11);
        inFlush = 1'b0;
        inMDop  = OP_MULT;
        inOpA   = $urandom;
        inOpB   = $urandom;
        settle();
        step();
        repeat (9) step();
        inFlush = 1'b1;
        step();
        inFlush = 1'b0;
        inStart = 1'b0;
        inMDop  = OP_NOP;
        settle();
        chk("flush idle", 32'(outStall), 32'd0);
        saw_done = 1'b0;
        repeat (30) begin
            step();
            if (outDone) saw_done = 1'b1;
        end
        chk("flush no_done", 32'(saw_done), 32'd0);
        chk("flush hi", outHI, 32'h11);
        chk("flush lo", outLO, 32'h22);

        // Asynchronous reset in the middle of a DIVU.
        inStart = 1'b1;
        inMDop  = OP_MTHI;
        inOpA   = 32'hA5A5_A5A5;
        step();
        inMDop = OP_MTLO;
        inOpA  = 32'h5A5A_5A5A;
        step();
        inMDop = OP_DIVU;
        inOpA  = $urandom;
        inOpB  = 32'($urandom_range(1, 1000));
        settle();
        step();
        repeat (20) step();
        chk("pre_reset busy", 32'(outStall), 32'd1);
        #2;
        RESET   = 1'b0;
        inStart = 1'b0;
        inMDop  = OP_MFHI;
        #1;
        chk("async_reset stall_done", 32'({outStall, outDone}), 32'b00);
        chk("async_reset hi", outHI, 32'd0);
        chk("async_reset lo", outLO, 32'd0);
        chk("async_reset mf", outMFresult, 32'd0);
        inMDop = OP_NOP;
        repeat (2) step();
        @(negedge CLOCK);
        RESET = 1'b1;
        step();
        chk("post_reset stall", 32'(outStall), 32'd0);
        chk("post_reset hi", outHI, 32'd0);
        chk("post_reset lo", outLO, 32'd0);
        run_arith(OP_MULTU, 32'd3, 32'd5, 1'b0, "multu_3x5", eh, el);
        chk("multu_3x5 lo_const", outLO, 32'd15);
        chk("multu_3x5 hi_const", outHI, 32'd0);
        retire("multu_3x5", eh, el);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(1, 4));
            ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            if (rop >= OP_DIV && $urandom_range(0, 2) == 0) rb = 32'($urandom_range(0, 15));
            run_arith(rop, ra, rb, 1'($urandom_range(0, 1)), "rand", eh, el);
            if ($urandom_range(0, 1) == 1) begin
                retire("rand", eh, el);
            end else begin
                step();
                inMDop = OP_MFHI;
                settle();
                chk("rand mfhi", outMFresult, eh);
                inMDop = OP_MFLO;
                settle();
                chk("rand mflo", outMFresult, el);
                ra     = $urandom;
                inMDop = OP_MTLO;
                inOpA  = ra;
                step();
                inMDop = OP_MFLO;
                settle();
                chk("rand mtlo_mflo", outMFresult, ra);
                inStart = 1'b0;
                inMDop  = OP_NOP;
                settle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have port CLOCK, input, 1 bit: the single clock, rising-edge active.
REQ-002 The block SHALL have port RESET, input, 1 bit: asynchronous reset, active low.
REQ-003 The block SHALL have port inStart, input, 1 bit: the ID/EX stage holds a valid multiply/divide/HI-LO instruction.
REQ-004 The block SHALL have port inMDop, input, 4 bits, with this encoding:
- 0000 NOP
- 0001 MULT
- 0010 MULTU
- 0011 DIV
- 0100 DIVU
- 0101 MFHI
- 0110 MFLO
- 0111 MTHI
- 1000 MTLO
- all other codes are NOP
REQ-005 The block SHALL have ports inOpA and inOpB, input, 32 bits each: operands rs and rt, taken from the ID/EX fromC/fromD outputs after forwarding.
REQ-006 The block SHALL have port inFlush, input, 1 bit: kill the EX-stage instruction and abort any operation in flight.
REQ-007 The block SHALL have port outStall, output, 1 bit: hold the PC, IF/ID and ID/EX pipeline registers.
REQ-008 The block SHALL have port outDone, output, 1 bit: registered one-cycle pulse that marks HI/LO updated by a MULT/DIV.
REQ-009 The block SHALL have ports outHI and outLO, output, 32 bits each: architectural HI/LO registers.
REQ-010 The block SHALL have port outMFresult, output, 32 bits: HI for MFHI, LO for MFLO, 0 for any other op (combinational).

Function
REQ-011 The block SHALL implement a state machine with states IDLE, CALC and FIX.
REQ-012 An arithmetic op (MULT/MULTU/DIV/DIVU) SHALL be accepted when all of these hold: state is IDLE, inStart=1, outDone=0 and inFlush=0.
- On the accepting edge E0: latch the operands, clear the 6-bit iteration counter, enter CALC.
REQ-013 CALC SHALL perform one radix-2 iteration per edge, 32 iterations (E1..E32), then enter FIX.
- Multiply: shift-add.
- Divide: restoring shift-subtract.
- Both work on 32-bit magnitudes; signed ops use absolute values.
REQ-014 At edge E33 in FIX, the block SHALL:
- apply sign correction;
- write HI/LO;
- set outDone=1 for exactly one cycle;
- return to IDLE.
REQ-015 Multiply results SHALL be the 64-bit product, with HI = bits 63:32 and LO = bits 31:0.
- MULT: two's-complement product.
- MULTU: unsigned product.
REQ-016 Divide results SHALL be LO = quotient, truncated toward zero, and HI = remainder, carrying the sign of the dividend for DIV.
REQ-017 For DIV with 0x80000000 / 0xFFFFFFFF, the block SHALL produce LO=0x80000000 and HI=0.
REQ-018 For divide by zero (DIV or DIVU), the block SHALL take the full 33-cycle latency, then write LO=0xFFFFFFFF and HI=inOpA as latched.
REQ-019 outStall SHALL equal (state!=IDLE) OR (inStart AND op is arithmetic AND outDone=0) OR (inStart AND op is MFHI/MFLO/MTHI/MTLO AND state!=IDLE).
REQ-020 In the outDone cycle, a held instruction with inStart=1 SHALL NOT restart, and outStall SHALL be 0 so the pipeline advances.
REQ-021 MTHI/MTLO SHALL write inOpA into HI/LO on the edge where state is IDLE, inStart=1 and inFlush=0.
REQ-022 MFHI/MFLO SHALL return the current HI/LO combinationally when in IDLE, including the value written at E33 from the next cycle onward.
REQ-023 inFlush=1 on any edge SHALL force IDLE and clear the counter.
- HI/LO stay unchanged, no outDone pulse is produced, and MTHI/MTLO are suppressed.
- Flush has priority over start.
REQ-024 inStart while in CALC/FIX SHALL be ignored; only the in-flight operation completes.

Reset
REQ-025 RESET=0 SHALL, asynchronously, force IDLE, counter=0, outDone=0, outHI=0 and outLO=0, with internal operand/partial registers set to 0.
REQ-026 Reset asserted mid-CALC SHALL discard the operation; after release, outStall=0 and HI/LO=0.
REQ-027 After RESET rises, the first accept SHALL occur on the first rising CLOCK edge with RESET=1 and the accept conditions met.

Verification
REQ-028 The bench SHALL drive MULT with A=0xFFFFFFFE (-2) and B=0x00000003, held with inStart=1, and check:
- outStall=1 from the start cycle through FIX;
- outDone at E33;
- HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-029 The bench SHALL drive MULTU with A=B=0xFFFFFFFF and check HI=0xFFFFFFFE and LO=0x00000001 after 33 cycles.
REQ-030 The bench SHALL drive DIV with A=-7 and B=2 and check LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1).
- It SHALL also drive DIVU with A=7 and B=0 and check LO=0xFFFFFFFF and HI=7.
REQ-031 The bench SHALL issue MFLO immediately after a DIV has been accepted and check:
- outStall=1 until outDone;
- outMFresult equals the new LO in the cycle after outDone.
REQ-032 The bench SHALL preset HI/LO via MTHI=0x11/MTLO=0x22, start MULT, and assert inFlush at E10, then check:
- IDLE next cycle;
- no outDone pulse;
- HI=0x11 and LO=0x22.
REQ-033 The bench SHALL assert RESET=0 at E20 of a DIVU and check:
- all outputs are 0 immediately, without waiting for a clock edge;
- after release, a new MULTU 3*5 gives LO=15 and HI=0.
